// File: rtl/daa_multiplier_core.sv
// Two-stage 8x8->16 multiplier: operand regs, Dadda-tree reduction, CPA, result reg.
// Define DAA_MULT_SIGNED_EN for two's complement (Baugh-Wooley) operation.
module daa_multiplier_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] result
);

  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [31:0] rows;
  logic [15:0] sum;

  function automatic logic [3:0] tgt(input int st);
    unique case (st)
      0:       tgt = 4'd6;
      1:       tgt = 4'd4;
      2:       tgt = 4'd3;
      default: tgt = 4'd2;
    endcase
  endfunction

  // Bit-level columns; heights are data-independent so the loops unroll
  // into a fixed network of full and half adders.
  function automatic logic [31:0] dadda(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic        cur [16][16];
    logic        nxt [16][16];
    int          h   [16];
    int          nh  [16];
    int          p;
    int          avail;
    int          d;
    logic        x;
    logic        y;
    logic        z;
    logic [15:0] r0;
    logic [15:0] r1;
    for (int c = 0; c < 16; c++) begin
      h[c] = 0;
      for (int r = 0; r < 16; r++) cur[c][r] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        x = a[j] & b[i];
`ifdef DAA_MULT_SIGNED_EN
        if ((i == 7) != (j == 7)) x = ~x;
`endif
        cur[i+j][h[i+j]] = x;
        h[i+j]++;
      end
    end
`ifdef DAA_MULT_SIGNED_EN
    cur[8][h[8]] = 1'b1;
    h[8]++;
    cur[15][h[15]] = 1'b1;
    h[15]++;
`endif
    for (int st = 0; st < 4; st++) begin
      d = int'(tgt(st));
      for (int c = 0; c < 16; c++) begin
        nh[c] = 0;
        for (int r = 0; r < 16; r++) nxt[c][r] = 1'b0;
      end
      for (int c = 0; c < 16; c++) begin
        p = 0;
        for (int t = 0; t < 8; t++) begin
          avail = h[c] - p;
          x = cur[c][p % 16];
          y = cur[c][(p + 1) % 16];
          z = cur[c][(p + 2) % 16];
          if (avail + nh[c] >= d + 2 && avail >= 3) begin
            nxt[c][nh[c] % 16] = x ^ y ^ z;
            nh[c]++;
            if (c < 15) begin
              nxt[c+1][nh[c+1] % 16] = (x & y) | (x & z) | (y & z);
              nh[c+1]++;
            end
            p += 3;
          end else if (avail + nh[c] >= d + 1 && avail >= 2) begin
            nxt[c][nh[c] % 16] = x ^ y;
            nh[c]++;
            if (c < 15) begin
              nxt[c+1][nh[c+1] % 16] = x & y;
              nh[c+1]++;
            end
            p += 2;
          end
        end
        for (int r = 0; r < 16; r++) begin
          if (r >= p && r < h[c]) begin
            nxt[c][nh[c] % 16] = cur[c][r];
            nh[c]++;
          end
        end
      end
      for (int c = 0; c < 16; c++) begin
        h[c] = nh[c];
        for (int r = 0; r < 16; r++) cur[c][r] = nxt[c][r];
      end
    end
    for (int c = 0; c < 16; c++) begin
      r0[c] = (h[c] > 0) ? cur[c][0] : 1'b0;
      r1[c] = (h[c] > 1) ? cur[c][1] : 1'b0;
    end
    dadda = {r1, r0};
  endfunction

  always_comb begin
    rows = dadda(a_r, b_r);
    sum  = rows[15:0] + rows[31:16];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r    <= 8'h00;
      b_r    <= 8'h00;
      result <= 16'h0000;
    end else begin
      a_r    <= A;
      b_r    <= B;
      result <= sum;
    end
  end

endmodule

// File: tb/tb_daa_multiplier_core.sv
// Directed and streaming checks for daa_multiplier_core.
// Follows DAA_MULT_SIGNED_EN to select signed or unsigned expectations.
module tb_daa_multiplier_core;

  logic        clk;
  logic        reset;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] result;

  int nvec;
  int nerr;

  daa_multiplier_core dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DAA_MULT_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  task automatic check_eq(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic signed [15:0] s;
    if (SGN) begin
      s = 16'($signed(a)) * 16'($signed(b));
      model = s;
    end else begin
      model = {8'h00, a} * {8'h00, b};
    end
  endfunction

  task automatic vec(
    input string       tag,
    input logic [7:0]  a,
    input logic [7:0]  b,
    input logic [15:0] exp_u,
    input logic [15:0] exp_s
  );
    @(negedge clk);
    A = a;
    B = b;
    repeat (2) @(negedge clk);
    check_eq(tag, result, SGN ? exp_s : exp_u);
  endtask

  logic [7:0]  sa [100];
  logic [7:0]  sb [100];
  logic [15:0] e1;
  logic [15:0] e2;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b0;
    A     = 8'hAA;
    B     = 8'h55;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold", result, 16'h0000);
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_first", result, 16'h0000);
    @(negedge clk);
    check_eq("rst_rel", result, SGN ? 16'hE372 : 16'h3872);

    vec("basic",   8'h0F, 8'h03, 16'h002D, 16'h002D);
    vec("carry",   8'hFF, 8'h02, 16'h01FE, 16'hFFFE);
    vec("ff_ff",   8'hFF, 8'hFF, 16'hFE01, 16'h0001);
    vec("zero",    8'h00, 8'hFF, 16'h0000, 16'h0000);
    vec("x80_x80", 8'h80, 8'h80, 16'h4000, 16'h4000);
    vec("x7f_x7f", 8'h7F, 8'h7F, 16'h3F01, 16'h3F01);
    vec("x80_x7f", 8'h80, 8'h7F, 16'h3F80, 16'hC080);

    for (int i = 0; i < 100; i++) begin
      sa[i] = 8'($urandom_range(0, 255));
      sb[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      if (i >= 2) check_eq("stream", result, model(sa[i-2], sb[i-2]));
      if (i < 100) begin
        A = sa[i];
        B = sb[i];
      end
    end

    e1 = model(8'hC3, 8'h5A);
    e2 = model(8'h37, 8'hE9);
    @(negedge clk);
    A = 8'h12;
    B = 8'h34;
    @(negedge clk);
    A = 8'h56;
    B = 8'h78;
    @(negedge clk);
    reset = 1'b0;
    A = 8'h9A;
    B = 8'hBC;
    @(negedge clk);
    check_eq("mid_rst", result, 16'h0000);
    reset = 1'b1;
    A = 8'hC3;
    B = 8'h5A;
    @(negedge clk);
    check_eq("mid_drop", result, 16'h0000);
    A = 8'h37;
    B = 8'hE9;
    @(negedge clk);
    check_eq("mid_resume", result, e1);
    @(negedge clk);
    check_eq("mid_next", result, e2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
